// File: rtl/sub_serial.sv
// Digit-serial unsigned subtractor: d = x - y as a width+1 bit two's-complement
// value, consuming `digit` bits per cycle through a single digit-wide adder cell.
`ifndef WIDTH
`define WIDTH 32
`endif

module sub_serial_digit #(
  parameter int digit = 4
) (
  input  logic [digit-1:0] a,
  input  logic [digit-1:0] b,
  input  logic             cin,
  output logic [digit-1:0] r,
  output logic             cout
);
  // a - b as a + ~b + cin; the carry out of the digit is the inverted borrow
  logic [digit:0] sum;
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{digit{1'b0}}, cin};
  assign r    = sum[digit-1:0];
  assign cout = sum[digit];
endmodule

module sub_serial #(
  parameter int width = `WIDTH,
  parameter int digit = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] x,
  input  logic [width-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width:0]   d,
  output logic             busy
);
  localparam int N  = (digit > 0) ? width / digit : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (digit < 1 || digit > width || (width % digit) != 0 || (digit & (digit - 1)) != 0) begin : g_bad_digit
    $error("sub_serial: digit must be a power of two dividing width");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [width-1:0] xs, ys, res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [digit-1:0] r_dig;
  logic             c_nxt;
  logic [width-1:0] res_nxt;

  sub_serial_digit #(.digit(digit)) u_digit (
    .a    (xs[digit-1:0]),
    .b    (ys[digit-1:0]),
    .cin  (carry),
    .r    (r_dig),
    .cout (c_nxt)
  );

  // New digit enters at the top so after N steps the LSD has reached bit 0
  assign res_nxt = width'({r_dig, res} >> digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      xs        <= '0;
      ys        <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      d         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xs       <= x;
          ys       <= y;
          carry    <= 1'b1;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          xs    <= xs >> digit;
          ys    <= ys >> digit;
          carry <= c_nxt;
          res   <= res_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            d         <= {~c_nxt, res_nxt};
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: directed table and corner sequences on digit=2, plus
// randomized traffic on digit=2/1/8 instances checked against (x - y) mod 2^(W+1).
module tb_sub_serial;
  localparam int W  = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [W-1:0] x, y;
  logic [NI-1:0] in_ready, out_valid, busy;
  logic [W:0] d [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_serial #(.width(W), .digit(g == 0 ? 2 : (g == 1 ? 1 : 8))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .x         (x),
      .y         (y),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .d         (d[g]),
      .busy      (busy[g])
    );
  end

  function automatic int dig_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Called at a negedge with instance 0 idle; full op with out_ready held high
  task automatic do_op(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic [W:0] exp, input string nm);
    int n;
    x = ax; y = ay; in_valid = 1'b1; out_ready = 1'b1;
    chk({nm, "_in_ready"}, in_ready[0], 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_d"}, d[0], exp);
    chk({nm, "_busy"}, busy[0], 1);
    chk({nm, "_in_ready_done"}, in_ready[0], 0);
    @(negedge clk);
    chk({nm, "_valid_drop"}, out_valid[0], 0);
    chk({nm, "_in_ready_idle"}, in_ready[0], 1);
    chk({nm, "_d_kept"}, d[0], exp);
    chk({nm, "_busy_idle"}, busy[0], 0);
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   d;
  } vec_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           e;
  } txn_t;

  txn_t q [NI][$];
  int   done_ops [NI];

  initial begin
    vec_t tbl [5];
    int   n, ecnt, exp_i;
    logic p_iv, p_or;
    logic [W-1:0] p_x, p_y;
    logic [NI-1:0] p_ir, p_ov;
    txn_t t;

    tbl[0] = '{8'd200, 8'd55,  9'h091};
    tbl[1] = '{8'd5,   8'd9,   9'h1FC};
    tbl[2] = '{8'd0,   8'd255, 9'h101};
    tbl[3] = '{8'd255, 8'd255, 9'h000};
    tbl[4] = '{8'd255, 8'd0,   9'h0FF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_d", d[0], 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_op(tbl[i].x, tbl[i].y, tbl[i].d, $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready is low, inputs ignored
    x = 8'd100; y = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      x = W'($urandom); y = W'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      chk("bp_d", d[0], 9'h063);
      chk("bp_out_valid", out_valid[0], 1);
      chk("bp_in_ready", in_ready[0], 0);
      chk("bp_busy", busy[0], 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", in_ready[0], 1);
    chk("bp_release_valid", out_valid[0], 0);

    // Reset on the second RUN edge discards the op
    x = 8'd77; y = 8'd12; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready[0], 1);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_d", d[0], 0);
    chk("midrst_busy", busy[0], 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid[0]) n++;
    end
    chk("midrst_no_result", n, 0);
    do_op(8'd10, 8'd3, 9'h007, "after_rst");

    // Back-to-back with in_valid and out_ready held high
    x = 8'd9; y = 8'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int e = 1; e <= 12; e++) begin
      if (e == 1) begin x = 8'd4; y = 8'd9; end
      @(negedge clk);
      chk("b2b_no_ready_busy", in_ready[0] & busy[0], 0);
      if (e == 4)  begin chk("b2b_ov1", out_valid[0], 1); chk("b2b_d1", d[0], 9'h005); end
      if (e == 5)  begin chk("b2b_idle", in_ready[0], 1); chk("b2b_ov1_drop", out_valid[0], 0); end
      if (e == 9)  chk("b2b_not_early", out_valid[0], 0);
      if (e == 10) begin chk("b2b_ov2", out_valid[0], 1); chk("b2b_d2", d[0], 9'h1FB); end
    end
    in_valid = 1'b0;

    // Randomized traffic on all three configurations
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ecnt = 0;
    p_ov = out_valid;
    while (ecnt < 40000 && (done_ops[0] < 1000 || done_ops[1] < 1000 || done_ops[2] < 1000)) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      x = W'($urandom); y = W'($urandom);
      p_iv = in_valid; p_or = out_ready; p_x = x; p_y = y;
      p_ir = in_ready; p_ov = out_valid;
      @(negedge clk);
      ecnt++;
      for (int k = 0; k < NI; k++) begin
        if (p_iv && p_ir[k]) q[k].push_back('{p_x, p_y, ecnt});
        if (out_valid[k] && !p_ov[k]) begin
          if (q[k].size() == 0) chk($sformatf("rand%0d_orphan", k), 1, 0);
          else begin
            t = q[k].pop_front();
            exp_i = ((int'(t.x) - int'(t.y)) + 512) % 512;
            chk($sformatf("rand%0d_d", k), 32'(d[k]), exp_i);
            chk($sformatf("rand%0d_latency", k), ecnt - t.e, W / dig_of(k));
            done_ops[k]++;
          end
        end
        if (p_ov[k] && out_valid[k] && !p_or) chk($sformatf("rand%0d_hold", k), 1, 1 & out_valid[k]);
      end
    end
    chk("rand_ops_done", (done_ops[0] >= 1000 && done_ops[1] >= 1000 && done_ops[2] >= 1000), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
